// File: rtl/alu_decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_decode_queue                                             |
// | Description : Data-processing ALU decoder feeding a small valid/ready FIFO  |
// |               of micro-ops, with a saturating illegal-opcode counter.      |
// |               Macro ALU_DECODE_CARRY_OPS_EN enables RSB/ADC/SBC decode.    |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module alu_decode_queue #(
    parameter int CTRL_W = 3,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_funct,
    input  logic              in_aluop,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_alu_ctrl,
    output logic [1:0]        out_flag_w,
    output logic              out_no_write,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  illegal_cnt,
    input  logic              cnt_clr
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_ENT_W = 3 + 2 + 1 + 1 + TAG_W;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    localparam logic [2:0] c_ADD = 3'b000;
    localparam logic [2:0] c_SUB = 3'b001;
    localparam logic [2:0] c_AND = 3'b010;
    localparam logic [2:0] c_ORR = 3'b011;
    localparam logic [2:0] c_EOR = 3'b100;
`ifdef ALU_DECODE_CARRY_OPS_EN
    localparam logic [2:0] c_RSB = 3'b101;
    localparam logic [2:0] c_ADC = 3'b110;
    localparam logic [2:0] c_SBC = 3'b111;
`endif

    logic [3:0]         w_cmd;
    logic               w_s;
    logic [2:0]         w_code;
    logic [1:0]         w_fw;
    logic               w_nw;
    logic               w_il;
    logic [c_ENT_W-1:0] w_entry;
    logic [c_ENT_W-1:0] w_head;
    logic               w_push;
    logic               w_pop;
    logic [CTRL_W-1:0]  w_ctrl_ext;

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [CNT_W-1:0]   r_illegal_cnt;

    assign w_cmd = in_funct[4:1];
    assign w_s   = in_funct[0];

    // Arithmetic ops write all four flags on S, logical ops only N and Z;
    // compares always update flags and never write back.
    always_comb begin
        w_code = c_ADD;
        w_fw   = 2'b00;
        w_nw   = 1'b0;
        w_il   = 1'b0;
        if (in_aluop) begin
            case (w_cmd)
                4'b0100: begin w_code = c_ADD; w_fw = w_s ? 2'b11 : 2'b00; end
                4'b0010: begin w_code = c_SUB; w_fw = w_s ? 2'b11 : 2'b00; end
                4'b0000: begin w_code = c_AND; w_fw = w_s ? 2'b10 : 2'b00; end
                4'b1100: begin w_code = c_ORR; w_fw = w_s ? 2'b10 : 2'b00; end
                4'b0001: begin w_code = c_EOR; w_fw = w_s ? 2'b10 : 2'b00; end
                4'b1010: begin w_code = c_SUB; w_fw = 2'b11; w_nw = 1'b1; end
                4'b1011: begin w_code = c_ADD; w_fw = 2'b11; w_nw = 1'b1; end
                4'b1000: begin w_code = c_AND; w_fw = 2'b10; w_nw = 1'b1; end
                4'b1001: begin w_code = c_EOR; w_fw = 2'b10; w_nw = 1'b1; end
`ifdef ALU_DECODE_CARRY_OPS_EN
                4'b0011: begin w_code = c_RSB; w_fw = w_s ? 2'b11 : 2'b00; end
                4'b0101: begin w_code = c_ADC; w_fw = w_s ? 2'b11 : 2'b00; end
                4'b0110: begin w_code = c_SBC; w_fw = w_s ? 2'b11 : 2'b00; end
`endif
                default: begin
                    w_code = c_ADD;
                    w_fw   = 2'b00;
                    w_nw   = 1'b1;
                    w_il   = 1'b1;
                end
            endcase
        end
    end

    assign w_entry   = {w_code, w_fw, w_nw, w_il, in_tag};
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (cnt_clr) begin
            r_illegal_cnt <= '0;
        end else if (w_push && w_il && (r_illegal_cnt != '1)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    // Empty queue presents all-zero data so stale entries never leak out.
    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        w_ctrl_ext      = '0;
        w_ctrl_ext[2:0] = w_head[c_ENT_W-1 -: 3];
    end

    assign out_alu_ctrl = w_ctrl_ext;
    assign out_flag_w   = w_head[TAG_W+3 -: 2];
    assign out_no_write = w_head[TAG_W+1];
    assign out_illegal  = w_head[TAG_W];
    assign out_tag      = w_head[TAG_W-1:0];
    assign illegal_cnt  = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_decode_queue                                          |
// | Description : Directed + random bench for alu_decode_queue against a       |
// |               queue-based reference model. Honours ALU_DECODE_CARRY_OPS_EN.|
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_alu_decode_queue;

    localparam int DEPTH   = 2;
    localparam int TAG_W   = 4;
    localparam int CNT_MAX = 255;

    typedef struct packed {
        logic [2:0]       a;
        logic [1:0]       fw;
        logic             nw;
        logic             il;
        logic [TAG_W-1:0] tag;
    } uop_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_funct = '0;
    logic       in_aluop = 1'b0;
    logic [3:0] in_tag = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_alu_ctrl;
    logic [1:0] out_flag_w;
    logic       out_no_write;
    logic       out_illegal;
    logic [3:0] out_tag;
    logic [7:0] illegal_cnt;
    logic       cnt_clr = 1'b0;

    int   checks = 0;
    int   failures = 0;
    uop_t q[$];
    int   mcnt = 0;

    alu_decode_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct     (in_funct),
        .in_aluop     (in_aluop),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_alu_ctrl (out_alu_ctrl),
        .out_flag_w   (out_flag_w),
        .out_no_write (out_no_write),
        .out_illegal  (out_illegal),
        .out_tag      (out_tag),
        .illegal_cnt  (illegal_cnt),
        .cnt_clr      (cnt_clr)
    );

    always #5 clk = ~clk;

    function automatic uop_t ref_decode(logic [4:0] f, logic aluop, logic [3:0] tag);
        uop_t u;
        int   op = 0;
        bit   arith = 1'b0;
        bit   cmp = 1'b0;
        bit   legal = 1'b1;
        u = '0;
        u.tag = tag;
        if (!aluop) return u;
        case (f[4:1])
            4'd4:  begin op = 0; arith = 1; end
            4'd2:  begin op = 1; arith = 1; end
            4'd0:  op = 2;
            4'd12: op = 3;
            4'd1:  op = 4;
            4'd10: begin op = 1; arith = 1; cmp = 1; end
            4'd11: begin op = 0; arith = 1; cmp = 1; end
            4'd8:  begin op = 2; cmp = 1; end
            4'd9:  begin op = 4; cmp = 1; end
`ifdef ALU_DECODE_CARRY_OPS_EN
            4'd3:  begin op = 5; arith = 1; end
            4'd5:  begin op = 6; arith = 1; end
            4'd6:  begin op = 7; arith = 1; end
`endif
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            u.nw = 1'b1;
            u.il = 1'b1;
        end else begin
            u.a  = 3'(op);
            u.fw = (f[0] || cmp) ? (arith ? 2'b11 : 2'b10) : 2'b00;
            u.nw = cmp;
        end
        return u;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare visible state with the model, then advance one clock and the model.
    task automatic cycle();
        uop_t h;
        uop_t e;
        bit   p_push;
        bit   p_pop;
        p_push = in_valid && (q.size() != DEPTH);
        p_pop  = (q.size() != 0) && out_ready;
        h = (q.size() != 0) ? q[0] : '0;
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("alu_ctrl", 32'(out_alu_ctrl), 32'(h.a));
        chk("flag_w", 32'(out_flag_w), 32'(h.fw));
        chk("no_write", 32'(out_no_write), 32'(h.nw));
        chk("illegal", 32'(out_illegal), 32'(h.il));
        chk("tag", 32'(out_tag), 32'(h.tag));
        chk("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
        e = ref_decode(in_funct, in_aluop, in_tag);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            mcnt = 0;
        end else begin
            if (p_pop) void'(q.pop_front());
            if (p_push) q.push_back(e);
            if (cnt_clr) mcnt = 0;
            else if (p_push && e.il && mcnt < CNT_MAX) mcnt++;
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] f, input logic op,
                         input logic [3:0] t, input logic rdy, input logic clr);
        in_valid  = v;
        in_funct  = f;
        in_aluop  = op;
        in_tag    = t;
        out_ready = rdy;
        cnt_clr   = clr;
        cycle();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        mcnt = 0;
    endtask

    initial begin
        do_reset();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_cnt", 32'(illegal_cnt), 32'd0);

        // ADD with S, then idle so the head is observed
        drive(1, 5'b01001, 1, 4'd3, 1, 0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_ctrl", 32'(out_alu_ctrl), 32'd0);
        chk("add_fw", 32'(out_flag_w), 32'd3);
        chk("add_tag", 32'(out_tag), 32'd3);
        drive(0, 5'b00000, 1, 4'd0, 1, 0);

        // CMP without S still writes arithmetic flags, no writeback
        drive(1, 5'b10100, 1, 4'd5, 1, 0);
        chk("cmp_ctrl", 32'(out_alu_ctrl), 32'd1);
        chk("cmp_fw", 32'(out_flag_w), 32'd3);
        chk("cmp_nw", 32'(out_no_write), 32'd1);
        drive(1, 5'b11000, 1, 4'd6, 1, 0);
        chk("orr_ctrl", 32'(out_alu_ctrl), 32'd3);
        chk("orr_fw", 32'(out_flag_w), 32'd0);
        drive(0, 5'b00000, 1, 4'd0, 1, 0);

        // Back-pressure: three pushes into a 2-deep queue
        drive(1, 5'b00101, 1, 4'd7, 0, 0);
        drive(1, 5'b00010, 1, 4'd8, 0, 0);
        chk("full_ready", 32'(in_ready), 32'd0);
        drive(1, 5'b01000, 1, 4'd9, 0, 0);
        chk("full_hold_tag", 32'(out_tag), 32'd7);
        drive(1, 5'b01000, 1, 4'd9, 1, 0);
        chk("full_pop_tag", 32'(out_tag), 32'd8);
        drive(1, 5'b01000, 1, 4'd9, 0, 0);
        drive(0, 5'b00000, 1, 4'd0, 1, 0);
        chk("order_tag", 32'(out_tag), 32'd9);
        drive(0, 5'b00000, 1, 4'd0, 1, 0);

        // Five MOVs, then clear colliding with another illegal push
        for (int i = 0; i < 5; i++) drive(1, 5'b11010, 1, 4'(i), 1, 0);
        drive(0, 5'b00000, 1, 4'd0, 1, 0);
        chk("mov_cnt5", 32'(illegal_cnt), 32'd5);
        drive(1, 5'b11010, 1, 4'd1, 1, 1);
        chk("clr_prio", 32'(illegal_cnt), 32'd0);
        drive(0, 5'b00000, 1, 4'd0, 1, 0);

        // ADC, and non-DP decode with arbitrary funct
        drive(1, 5'b01011, 1, 4'd2, 1, 0);
`ifdef ALU_DECODE_CARRY_OPS_EN
        chk("adc_ctrl", 32'(out_alu_ctrl), 32'd6);
        chk("adc_fw", 32'(out_flag_w), 32'd3);
`else
        chk("adc_illegal", 32'(out_illegal), 32'd1);
        chk("adc_cnt", 32'(illegal_cnt), 32'd1);
`endif
        drive(1, 5'b11111, 0, 4'd4, 1, 0);
        chk("nondp_ctrl", 32'(out_alu_ctrl), 32'd0);
        chk("nondp_fw", 32'(out_flag_w), 32'd0);
        drive(0, 5'b00000, 1, 4'd0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 3) != 0),
                  4'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end

        // Saturation of the illegal counter
        drive(0, 5'b00000, 1, 4'd0, 1, 1);
        for (int i = 0; i < CNT_MAX + 5; i++) drive(1, 5'b11110, 1, 4'(i), 1, 0);
        drive(0, 5'b00000, 1, 4'd0, 1, 0);
        chk("cnt_sat", 32'(illegal_cnt), 32'(CNT_MAX));

        // Reset with a full queue discards everything
        drive(1, 5'b01000, 1, 4'd1, 0, 0);
        drive(1, 5'b01000, 1, 4'd2, 0, 0);
        do_reset();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_tag", 32'(out_tag), 32'd0);
        drive(0, 5'b00000, 1, 4'd0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
